// File: rtl/alarm_time_ctrl.sv
// Timekeeping and alarm control core.
// Drives the 7-seg digit bus, banner codes and buzzer.
module alarm_time_ctrl #(
    parameter int unsigned BANNER_SECS = 2,
    parameter int unsigned RING_SECS   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc_min,
    input  logic       btn_inc_hr,
    input  logic       btn_alarm_en,
    output logic [5:0] sec,
    output logic [3:0] min2,
    output logic [3:0] min1,
    output logic [3:0] H2,
    output logic [2:0] H1,
    output logic       condition,
    output logic [3:0] Amin2,
    output logic [3:0] Amin1,
    output logic [3:0] AH2,
    output logic [1:0] AH1,
    output logic       alarm_en,
    output logic       buzzer
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RING      = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [3:0] m2_q, m2_d, m1_q, m1_d, h2_q, h2_d;
    logic [1:0] h1_q, h1_d;
    logic [3:0] am2_q, am2_d, am1_q, am1_d, ah2_q, ah2_d;
    logic [1:0] ah1_q, ah1_d;
    logic       en_q, en_d;
    logic [3:0] ban_q, ban_d;
    logic [7:0] ring_q, ring_d;
    logic [2:0] dh1_q, dh1_d;
    logic [3:0] dh2_q, dh2_d, dm1_q, dm1_d, dm2_q, dm2_d;
    logic       cond_q, cond_d, buzz_q, buzz_d;
    logic       b_hr, b_min, b_en, any_btn;

    // BCD minutes 00..59 with wrap, no carry out
    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] o);
        logic [7:0] r;
        if (o == 4'd9) begin
            if (t == 4'd5) r = 8'h00;
            else           r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, o + 4'd1};
        end
        return r;
    endfunction

    // BCD hours 00..23 with wrap
    function automatic logic [5:0] hr_inc(input logic [1:0] t, input logic [3:0] o);
        logic [5:0] r;
        if (t == 2'd2 && o == 4'd3) r = 6'h00;
        else if (o == 4'd9)         r = {t + 2'd1, 4'd0};
        else                        r = {t, o + 4'd1};
        return r;
    endfunction

    // Next-state: time counting, mode FSM, buttons and display mux
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        m2_d    = m2_q;
        m1_d    = m1_q;
        h2_d    = h2_q;
        h1_d    = h1_q;
        am2_d   = am2_q;
        am1_d   = am1_q;
        ah2_d   = ah2_q;
        ah1_d   = ah1_q;
        en_d    = en_q;
        ban_d   = ban_q;
        ring_d  = ring_q;

        b_hr    = ~btn_mode & btn_inc_hr;
        b_min   = ~btn_mode & ~btn_inc_hr & btn_inc_min;
        b_en    = ~btn_mode & ~btn_inc_hr & ~btn_inc_min & btn_alarm_en;
        any_btn = btn_mode | btn_inc_hr | btn_inc_min | btn_alarm_en;

        if (tick_1hz && state_q != SET_TIME) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                {m1_d, m2_d} = min_inc(m1_q, m2_q);
                if (m1_q == 4'd5 && m2_q == 4'd9)
                    {h1_d, h2_d} = hr_inc(h1_q, h2_q);
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        unique case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_TIME;
                    sec_d   = 6'd0;
                end else begin
                    if (b_en) en_d = ~en_q;
                    if (en_q && tick_1hz && sec_d == 6'd0 &&
                        {h1_d, h2_d, m1_d, m2_d} == {ah1_q, ah2_q, am1_q, am2_q}) begin
                        state_d = RING;
                        ring_d  = 8'(RING_SECS);
                    end
                end
            end
            SET_TIME: begin
                if (btn_mode) begin
                    state_d = SET_ALARM;
                    ban_d   = 4'(BANNER_SECS);
                end else if (b_hr) begin
                    {h1_d, h2_d} = hr_inc(h1_q, h2_q);
                end else if (b_min) begin
                    {m1_d, m2_d} = min_inc(m1_q, m2_q);
                end else if (b_en) begin
                    en_d = ~en_q;
                end
            end
            SET_ALARM: begin
                if (btn_mode) begin
                    state_d = RUN;
                    ban_d   = 4'd0;
                end else begin
                    if (tick_1hz && ban_q != 4'd0) ban_d = ban_q - 4'd1;
                    if (b_hr)  {ah1_d, ah2_d} = hr_inc(ah1_q, ah2_q);
                    if (b_min) {am1_d, am2_d} = min_inc(am1_q, am2_q);
                    if (b_en)  en_d = ~en_q;
                end
            end
            RING: begin
                if (any_btn) begin
                    state_d = RUN;
                    ring_d  = 8'd0;
                end else if (tick_1hz) begin
                    if (ring_q <= 8'd1) begin
                        state_d = RUN;
                        ring_d  = 8'd0;
                    end else begin
                        ring_d = ring_q - 8'd1;
                    end
                end
            end
        endcase

        dh1_d  = {1'b0, h1_d};
        dh2_d  = h2_d;
        dm1_d  = m1_d;
        dm2_d  = m2_d;
        cond_d = 1'b0;
        if (state_d == SET_ALARM) begin
            if (ban_d != 4'd0) begin
                dh1_d = 3'b011;
                dh2_d = 4'hA;
                dm1_d = 4'hA;
                dm2_d = 4'hA;
            end else begin
                cond_d = 1'b1;
            end
        end else if (state_d == RING && sec_d[0]) begin
            dh1_d = 3'b111;
            dh2_d = 4'hF;
            dm1_d = 4'hF;
            dm2_d = 4'hF;
        end
        buzz_d = (state_d == RING);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            sec_q   <= '0;
            m2_q    <= '0;
            m1_q    <= '0;
            h2_q    <= '0;
            h1_q    <= '0;
            am2_q   <= '0;
            am1_q   <= '0;
            ah2_q   <= '0;
            ah1_q   <= '0;
            en_q    <= 1'b0;
            ban_q   <= '0;
            ring_q  <= '0;
            dh1_q   <= '0;
            dh2_q   <= '0;
            dm1_q   <= '0;
            dm2_q   <= '0;
            cond_q  <= 1'b0;
            buzz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            m2_q    <= m2_d;
            m1_q    <= m1_d;
            h2_q    <= h2_d;
            h1_q    <= h1_d;
            am2_q   <= am2_d;
            am1_q   <= am1_d;
            ah2_q   <= ah2_d;
            ah1_q   <= ah1_d;
            en_q    <= en_d;
            ban_q   <= ban_d;
            ring_q  <= ring_d;
            dh1_q   <= dh1_d;
            dh2_q   <= dh2_d;
            dm1_q   <= dm1_d;
            dm2_q   <= dm2_d;
            cond_q  <= cond_d;
            buzz_q  <= buzz_d;
        end
    end

    assign sec       = sec_q;
    assign min2      = dm2_q;
    assign min1      = dm1_q;
    assign H2        = dh2_q;
    assign H1        = dh1_q;
    assign condition = cond_q;
    assign Amin2     = am2_q;
    assign Amin1     = am1_q;
    assign AH2       = ah2_q;
    assign AH1       = ah1_q;
    assign alarm_en  = en_q;
    assign buzzer    = buzz_q;

endmodule
